reg_bank_pc: RTL and testbench

Parametrised general-purpose register bank with a dedicated program counter, for the multi-cycle datapath. It provides two independent read ports with optional write-through bypass, one write port, and a PC that self-increments. A per-register busy scoreboard lets the control FSM detect read-after-write hazards against pending multi-cycle results, such as memory loads.

---
 rtl/reg_bank_pc.sv | 97 +++++++++
 tb/tb_reg_bank_pc.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_pc.sv
// General-purpose register bank with a self-incrementing PC in the top slot,
// two bypassed combinational read ports, a busy scoreboard and a debug tap.
module reg_bank_pc #(
   parameter int              WIDTH    = 16,
   parameter int              NUM_REGS = 8,
   parameter logic [WIDTH-1:0] PC_STEP = WIDTH'(1),
   parameter logic [WIDTH-1:0] PC_RESET = '0,
   parameter int              BYPASS   = 1,
   parameter int              ZERO_R0  = 0,
   localparam int             AW       = $clog2(NUM_REGS)
) (
   input  logic                Clock,
   input  logic                reset,
   input  logic                Wr,
   input  logic [AW-1:0]       waddr,
   input  logic [WIDTH-1:0]    wdata,
   input  logic                incr_pc,
   input  logic [AW-1:0]       raddr_a,
   input  logic [AW-1:0]       raddr_b,
   output logic [WIDTH-1:0]    qa,
   output logic [WIDTH-1:0]    qb,
   input  logic                busy_set,
   input  logic [AW-1:0]       busy_addr,
   output logic                hazard_a,
   output logic                hazard_b,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [WIDTH-1:0]    outPC,
   input  logic [AW-1:0]       dbg_sel,
   output logic [WIDTH-1:0]    dbg_q
);

   localparam int PC = NUM_REGS - 1;

   logic [NUM_REGS-1:0][WIDTH-1:0] regs;
   logic [NUM_REGS-1:0]            busy;
   logic                           wr_eff;

   // With ZERO_R0 a write to r0 is dropped entirely, including for bypass.
   assign wr_eff = Wr && !((ZERO_R0 != 0) && (waddr == '0));

   for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
      logic             wr_hit;
      logic             clr_hit;
      logic             set_hit;
      logic [WIDTH-1:0] r;
      logic             b;

      assign wr_hit  = wr_eff && (waddr == AW'(i));
      assign clr_hit = Wr && (waddr == AW'(i));
      assign set_hit = busy_set && (busy_addr == AW'(i)) && !((ZERO_R0 != 0) && (i == 0));

      if (i == PC) begin : g_pc
         // An explicit PC write takes priority over the increment.
         always_ff @(posedge Clock or negedge reset) begin
            if (!reset)       r <= PC_RESET;
            else if (wr_hit)  r <= wdata;
            else if (incr_pc) r <= r + PC_STEP;
         end
      end else begin : g_gpr
         always_ff @(posedge Clock or negedge reset) begin
            if (!reset)      r <= '0;
            else if (wr_hit) r <= wdata;
         end
      end

      // A new producer marked in the same cycle as a write keeps the register pending.
      always_ff @(posedge Clock or negedge reset) begin
         if (!reset)       b <= 1'b0;
         else if (set_hit) b <= 1'b1;
         else if (clr_hit) b <= 1'b0;
      end

      assign regs[i] = r;
      assign busy[i] = b;
   end

   always_comb begin
      qa = regs[raddr_a];
      if ((BYPASS != 0) && wr_eff && (waddr == raddr_a)) qa = wdata;
   end

   always_comb begin
      qb = regs[raddr_b];
      if ((BYPASS != 0) && wr_eff && (waddr == raddr_b)) qb = wdata;
   end

   assign hazard_a = busy[raddr_a] && !((BYPASS != 0) && Wr && (waddr == raddr_a));
   assign hazard_b = busy[raddr_b] && !((BYPASS != 0) && Wr && (waddr == raddr_b));
   assign busy_vec = busy;
   assign outPC    = regs[PC];

   always_ff @(posedge Clock or negedge reset) begin
      if (!reset) dbg_q <= '0;
      else        dbg_q <= regs[dbg_sel];
   end

endmodule

// File: tb/tb_reg_bank_pc.sv
// Bench for reg_bank_pc: a default instance and a no-bypass/zero-r0 instance share
// stimulus and are checked against an array-based reference model.
module tb_reg_bank_pc;

   logic        Clock = 1'b0;
   logic        reset = 1'b1;
   logic        Wr, incr_pc, busy_set;
   logic [2:0]  waddr, raddr_a, raddr_b, busy_addr, dbg_sel;
   logic [15:0] wdata;

   logic [1:0][15:0] qa_o, qb_o, pc_o, dbg_o;
   logic [1:0][7:0]  busy_o;
   logic [1:0]       hza_o, hzb_o;

   // Configuration of instance c: bit/element c.
   localparam logic [1:0]       BP   = 2'b01;
   localparam logic [1:0]       ZR   = 2'b10;
   localparam logic [1:0][15:0] STEP = {16'd3, 16'd1};
   localparam logic [1:0][15:0] PRST = {16'h0100, 16'h0000};

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] m_reg  [2][8];
   logic [7:0]  m_busy [2];
   logic [15:0] m_dbg  [2];

   always #5 Clock = ~Clock;

   reg_bank_pc dut0 (
      .Clock(Clock), .reset(reset), .Wr(Wr), .waddr(waddr), .wdata(wdata),
      .incr_pc(incr_pc), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .qa(qa_o[0]), .qb(qb_o[0]), .busy_set(busy_set), .busy_addr(busy_addr),
      .hazard_a(hza_o[0]), .hazard_b(hzb_o[0]), .busy_vec(busy_o[0]),
      .outPC(pc_o[0]), .dbg_sel(dbg_sel), .dbg_q(dbg_o[0]));

   reg_bank_pc #(.PC_STEP(16'd3), .PC_RESET(16'h0100), .BYPASS(0), .ZERO_R0(1)) dut1 (
      .Clock(Clock), .reset(reset), .Wr(Wr), .waddr(waddr), .wdata(wdata),
      .incr_pc(incr_pc), .raddr_a(raddr_a), .raddr_b(raddr_b),
      .qa(qa_o[1]), .qb(qb_o[1]), .busy_set(busy_set), .busy_addr(busy_addr),
      .hazard_a(hza_o[1]), .hazard_b(hzb_o[1]), .busy_vec(busy_o[1]),
      .outPC(pc_o[1]), .dbg_sel(dbg_sel), .dbg_q(dbg_o[1]));

   // ---------------- reference model ----------------
   function automatic logic we_eff(int c);
      return Wr && !(ZR[c] && waddr == 3'd0);
   endfunction

   function automatic logic [15:0] exp_q(int c, logic [2:0] ra);
      if (BP[c] && we_eff(c) && waddr == ra) return wdata;
      return m_reg[c][ra];
   endfunction

   function automatic logic exp_hz(int c, logic [2:0] ra);
      return m_busy[c][ra] && !(BP[c] && Wr && waddr == ra);
   endfunction

   always @(posedge Clock or negedge reset) begin
      if (!reset) begin
         for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 8; i++) m_reg[c][i] <= (i == 7) ? PRST[c] : 16'h0000;
            m_busy[c] <= 8'h00;
            m_dbg[c]  <= 16'h0000;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            m_dbg[c] <= m_reg[c][dbg_sel];
            if (incr_pc && !(we_eff(c) && waddr == 3'd7)) m_reg[c][7] <= m_reg[c][7] + STEP[c];
            if (we_eff(c)) m_reg[c][waddr] <= wdata;
            if (Wr) m_busy[c][waddr] <= 1'b0;
            if (busy_set && !(ZR[c] && busy_addr == 3'd0)) m_busy[c][busy_addr] <= 1'b1;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      Wr = 0; incr_pc = 0; busy_set = 0;
      waddr = 0; raddr_a = 0; raddr_b = 0; busy_addr = 0; dbg_sel = 0; wdata = 0;
   endtask

   task automatic tick();
      @(posedge Clock); #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      raddr_a = 3'd3; raddr_b = 3'd7;
      #1 reset = 1'b0;
      #1;
      n_cmp++; if (qa_o[0] !== 16'h0) begin n_err++; $display("FAIL rst_qa0: got %h want 0000", qa_o[0]); end
      n_cmp++; if (qb_o[1] !== 16'h0100) begin n_err++; $display("FAIL rst_qb1_pc: got %h want 0100", qb_o[1]); end
      n_cmp++; if (pc_o[0] !== 16'h0) begin n_err++; $display("FAIL rst_pc0: got %h want 0000", pc_o[0]); end
      n_cmp++; if (pc_o[1] !== 16'h0100) begin n_err++; $display("FAIL rst_pc1: got %h want 0100", pc_o[1]); end
      n_cmp++; if (busy_o !== 16'h0) begin n_err++; $display("FAIL rst_busy: got %h want 0000", busy_o); end
      n_cmp++; if (hza_o !== 2'b00 || hzb_o !== 2'b00) begin n_err++; $display("FAIL rst_hazard: got %b/%b want 00/00", hza_o, hzb_o); end
      n_cmp++; if (dbg_o !== 32'h0) begin n_err++; $display("FAIL rst_dbg: got %h want 0", dbg_o); end
      @(negedge Clock) reset = 1'b1;
   endtask

   task automatic test_pc_incr();
      incr_pc = 1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         n_cmp++; if (pc_o[0] !== 16'(k)) begin n_err++; $display("FAIL pc_incr0_%0d: got %h want %h", k, pc_o[0], 16'(k)); end
         n_cmp++; if (pc_o[1] !== 16'(16'h0100 + 3*k)) begin n_err++; $display("FAIL pc_incr1_%0d: got %h want %h", k, pc_o[1], 16'(16'h0100 + 3*k)); end
      end
      incr_pc = 0;
   endtask

   task automatic test_write_bypass();
      Wr = 1; waddr = 3'd2; wdata = 16'hA5A5; raddr_a = 3'd2;
      #1;
      n_cmp++; if (qa_o[0] !== 16'hA5A5) begin n_err++; $display("FAIL bypass_qa0: got %h want a5a5", qa_o[0]); end
      n_cmp++; if (qa_o[1] !== 16'h0000) begin n_err++; $display("FAIL nobypass_qa1: got %h want 0000", qa_o[1]); end
      tick(); Wr = 0; #1;
      n_cmp++; if (qa_o[0] !== 16'hA5A5) begin n_err++; $display("FAIL wr_lat_qa0: got %h want a5a5", qa_o[0]); end
      n_cmp++; if (qa_o[1] !== 16'hA5A5) begin n_err++; $display("FAIL wr_lat_qa1: got %h want a5a5", qa_o[1]); end
   endtask

   task automatic test_pc_collisions();
      Wr = 1; waddr = 3'd7; wdata = 16'hFFFF;
      tick(); Wr = 0; incr_pc = 1; raddr_a = 3'd7; #1;
      n_cmp++; if (qa_o[0] !== 16'hFFFF) begin n_err++; $display("FAIL pc_read_old: got %h want ffff", qa_o[0]); end
      tick(); incr_pc = 0;
      n_cmp++; if (pc_o[0] !== 16'h0000) begin n_err++; $display("FAIL pc_wrap0: got %h want 0000", pc_o[0]); end
      n_cmp++; if (pc_o[1] !== 16'h0002) begin n_err++; $display("FAIL pc_wrap1: got %h want 0002", pc_o[1]); end
      Wr = 1; waddr = 3'd7; wdata = 16'h0040; incr_pc = 1;
      tick(); Wr = 0; incr_pc = 0;
      n_cmp++; if (pc_o[0] !== 16'h0040) begin n_err++; $display("FAIL pc_wr_vs_incr0: got %h want 0040", pc_o[0]); end
      n_cmp++; if (pc_o[1] !== 16'h0040) begin n_err++; $display("FAIL pc_wr_vs_incr1: got %h want 0040", pc_o[1]); end
   endtask

   task automatic test_scoreboard();
      busy_set = 1; busy_addr = 3'd3;
      tick(); busy_set = 0; raddr_b = 3'd3; #1;
      n_cmp++; if (hzb_o !== 2'b11) begin n_err++; $display("FAIL sb_hazard: got %b want 11", hzb_o); end
      n_cmp++; if (busy_o[0] !== 8'h08) begin n_err++; $display("FAIL sb_busy: got %h want 08", busy_o[0]); end
      Wr = 1; waddr = 3'd3; wdata = 16'h1234; #1;
      n_cmp++; if (hzb_o[0] !== 1'b0 || qb_o[0] !== 16'h1234) begin n_err++; $display("FAIL sb_resolve0: got %b/%h want 0/1234", hzb_o[0], qb_o[0]); end
      n_cmp++; if (hzb_o[1] !== 1'b1 || qb_o[1] !== 16'h0000) begin n_err++; $display("FAIL sb_resolve1: got %b/%h want 1/0000", hzb_o[1], qb_o[1]); end
      tick(); Wr = 0; #1;
      n_cmp++; if (busy_o !== 16'h0000) begin n_err++; $display("FAIL sb_clear: got %h want 0000", busy_o); end
   endtask

   task automatic test_set_write_collision();
      busy_set = 1; busy_addr = 3'd5; Wr = 1; waddr = 3'd5; wdata = 16'h0F0F;
      tick(); busy_set = 0; Wr = 0; raddr_a = 3'd5; #1;
      n_cmp++; if (qa_o[0] !== 16'h0F0F) begin n_err++; $display("FAIL coll_data: got %h want 0f0f", qa_o[0]); end
      n_cmp++; if (busy_o[0] !== 8'h20 || hza_o[0] !== 1'b1) begin n_err++; $display("FAIL coll_busy: got %h/%b want 20/1", busy_o[0], hza_o[0]); end
      Wr = 1; tick(); Wr = 0;
   endtask

   task automatic test_zero_r0();
      Wr = 1; waddr = 3'd0; wdata = 16'hFFFF; raddr_a = 3'd0; busy_set = 1; busy_addr = 3'd0; #1;
      n_cmp++; if (qa_o[1] !== 16'h0000 || qa_o[0] !== 16'hFFFF) begin n_err++; $display("FAIL zr_bypass: got %h/%h want 0000/ffff", qa_o[1], qa_o[0]); end
      tick(); Wr = 0; busy_set = 0; #1;
      n_cmp++; if (qa_o[1] !== 16'h0000 || qa_o[0] !== 16'hFFFF) begin n_err++; $display("FAIL zr_store: got %h/%h want 0000/ffff", qa_o[1], qa_o[0]); end
      n_cmp++; if (busy_o[1][0] !== 1'b0 || busy_o[0][0] !== 1'b1) begin n_err++; $display("FAIL zr_busy: got %b/%b want 0/1", busy_o[1][0], busy_o[0][0]); end
      Wr = 1; wdata = 16'h0000; tick(); Wr = 0;
   endtask

   task automatic test_dbg();
      dbg_sel = 3'd5; Wr = 1; waddr = 3'd5; wdata = 16'h5555;
      tick(); Wr = 0;
      n_cmp++; if (dbg_o[0] !== 16'h0F0F || dbg_o[1] !== 16'h0F0F) begin n_err++; $display("FAIL dbg_lag: got %h/%h want 0f0f/0f0f", dbg_o[0], dbg_o[1]); end
      tick();
      n_cmp++; if (dbg_o[0] !== 16'h5555 || dbg_o[1] !== 16'h5555) begin n_err++; $display("FAIL dbg_new: got %h/%h want 5555/5555", dbg_o[0], dbg_o[1]); end
   endtask

   task automatic test_async_reset();
      idle();
      Wr = 1; waddr = 3'd1; wdata = 16'h1111; tick();
      waddr = 3'd2; wdata = 16'h2222; tick();
      Wr = 0; busy_set = 1; busy_addr = 3'd1; tick();
      busy_addr = 3'd2; tick();
      busy_set = 0;
      n_cmp++; if (busy_o !== {8'h06, 8'h06}) begin n_err++; $display("FAIL ar_pre_busy: got %h want 0606", busy_o); end
      Wr = 1; waddr = 3'd4; wdata = 16'h4444; incr_pc = 1; busy_set = 1; busy_addr = 3'd4;
      raddr_a = 3'd1; raddr_b = 3'd7;
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (qa_o !== 32'h0) begin n_err++; $display("FAIL ar_qa: got %h want 0", qa_o); end
      n_cmp++; if (qb_o[0] !== 16'h0 || pc_o[0] !== 16'h0 || pc_o[1] !== 16'h0100) begin n_err++; $display("FAIL ar_pc: got %h/%h/%h want 0000/0000/0100", qb_o[0], pc_o[0], pc_o[1]); end
      n_cmp++; if (busy_o !== 16'h0 || hza_o !== 2'b00) begin n_err++; $display("FAIL ar_busy: got %h/%b want 0000/00", busy_o, hza_o); end
      tick(); idle(); raddr_a = 3'd4; #1;
      n_cmp++; if (qa_o !== 32'h0 || busy_o !== 16'h0) begin n_err++; $display("FAIL ar_inflight: got %h/%h want 0/0", qa_o, busy_o); end
      @(negedge Clock) reset = 1'b1;
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         tick();
         Wr        = ($urandom_range(0, 1) == 1);
         waddr     = 3'($urandom_range(0, 7));
         wdata     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         incr_pc   = ($urandom_range(0, 2) == 0);
         busy_set  = ($urandom_range(0, 3) == 0);
         busy_addr = 3'($urandom_range(0, 7));
         raddr_a   = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
         raddr_b   = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
         dbg_sel   = 3'($urandom_range(0, 7));
         #2;
         for (int c = 0; c < 2; c++) begin
            n_cmp++; if (qa_o[c] !== exp_q(c, raddr_a)) begin n_err++; $display("FAIL rnd_qa%0d @%0d: got %h want %h", c, n, qa_o[c], exp_q(c, raddr_a)); end
            n_cmp++; if (qb_o[c] !== exp_q(c, raddr_b)) begin n_err++; $display("FAIL rnd_qb%0d @%0d: got %h want %h", c, n, qb_o[c], exp_q(c, raddr_b)); end
            n_cmp++; if (hza_o[c] !== exp_hz(c, raddr_a) || hzb_o[c] !== exp_hz(c, raddr_b)) begin n_err++; $display("FAIL rnd_hz%0d @%0d: got %b%b want %b%b", c, n, hza_o[c], hzb_o[c], exp_hz(c, raddr_a), exp_hz(c, raddr_b)); end
            n_cmp++; if (pc_o[c] !== m_reg[c][7]) begin n_err++; $display("FAIL rnd_pc%0d @%0d: got %h want %h", c, n, pc_o[c], m_reg[c][7]); end
            n_cmp++; if (busy_o[c] !== m_busy[c]) begin n_err++; $display("FAIL rnd_busy%0d @%0d: got %h want %h", c, n, busy_o[c], m_busy[c]); end
            n_cmp++; if (dbg_o[c] !== m_dbg[c]) begin n_err++; $display("FAIL rnd_dbg%0d @%0d: got %h want %h", c, n, dbg_o[c], m_dbg[c]); end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_pc_incr();
      test_write_bypass();
      test_pc_collisions();
      test_scoreboard();
      test_set_write_collision();
      test_zero_r0();
      test_dbg();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
